// File: rtl/zram_bus_bridge_pkg.sv
// Shared types for the 68K-to-Z80-sound-RAM bridge: FSM states, latched request and open-bus value.
package zram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      TAIL,
      ACK,
      WREL
   } zram_state_e;

   localparam logic [7:0] ZRAM_OPEN_BUS = 8'hFF;

   // Request fields frozen at the IDLE edge; later bus changes must not leak into the access.
   typedef struct packed {
      logic        we;
      logic        uds_n;
      logic        lds_n;
      logic [15:0] din;
   } zram_req_t;

   function automatic logic [7:0] zram_lane_byte(input logic sel_n, input logic [7:0] data);
      return sel_n ? ZRAM_OPEN_BUS : data;
   endfunction

endpackage

// File: rtl/zram_bus_bridge_if.sv
// 68K-side request/acknowledge bus of the sound RAM bridge; master is the bus decode, slave is the bridge.
interface zram_bus_bridge_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-2:0] addr;
   logic                  uds_n;
   logic                  lds_n;
   logic [15:0]           din;
   logic [15:0]           dout;
   logic                  ack;

   modport master (
      output req, we, addr, uds_n, lds_n, din,
      input  dout, ack
   );

   modport slave (
      input  req, we, addr, uds_n, lds_n, din,
      output dout, ack
   );
endinterface

// File: rtl/zram_bus_bridge.sv
// Splits 68K word accesses into even/odd byte cycles on the Z80 sound RAM; ZRAM_BUSGATE_EN gates starts on z80_busack.
// Latency: ack 4 cycles (read), 3 (write), 1 (no lane) from the request edge; read data returned with ack.
// Backpressure: requests wait in IDLE (and for the Z80 bus grant when gated); after ack, cpu_req must drop before the next access.
module zram_bus_bridge
   import zram_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   zram_bus_bridge_if.slave      cpu,
`ifdef ZRAM_BUSGATE_EN
   input  logic                  z80_busack,
`endif
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [7:0]            ram_din,
   input  logic [7:0]            ram_dout
);

   zram_state_e           state_q;
   zram_state_e           state_d;
   zram_req_t             req_q;
   logic [ADDR_WIDTH-2:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_hold_q;
   logic [7:0]            hi_byte_q;
   logic [15:0]           dout_q;
   logic                  start;
   logic                  no_lane;

`ifdef ZRAM_BUSGATE_EN
   assign start = cpu.req & z80_busack;
`else
   assign start = cpu.req;
`endif

   assign no_lane  = cpu.uds_n & cpu.lds_n;
   assign cpu.dout = dout_q;

   always_comb begin
      state_d  = state_q;
      ram_addr = addr_hold_q;
      ram_we   = 1'b0;
      ram_din  = '0;
      cpu.ack  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = no_lane ? ACK : HI;
            end
         end
         HI: begin
            ram_addr = {addr_q, 1'b0};
            ram_we   = req_q.we & ~req_q.uds_n;
            ram_din  = req_q.din[15:8];
            state_d  = LO;
         end
         LO: begin
            ram_addr = {addr_q, 1'b1};
            ram_we   = req_q.we & ~req_q.lds_n;
            ram_din  = req_q.din[7:0];
            state_d  = req_q.we ? ACK : TAIL;
         end
         TAIL: begin
            state_d = ACK;
         end
         ACK: begin
            cpu.ack = 1'b1;
            state_d = WREL;
         end
         WREL: begin
            if (!cpu.req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The even byte is staged so cpu_dout only changes when a whole read completes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= '0;
         addr_q      <= '0;
         addr_hold_q <= '0;
         hi_byte_q   <= '0;
         dout_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_hold_q <= ram_addr;
         case (state_q)
            IDLE: begin
               if (start) begin
                  req_q  <= '{we: cpu.we, uds_n: cpu.uds_n, lds_n: cpu.lds_n, din: cpu.din};
                  addr_q <= cpu.addr;
                  if (no_lane && !cpu.we) begin
                     dout_q <= {ZRAM_OPEN_BUS, ZRAM_OPEN_BUS};
                  end
               end
            end
            LO: begin
               if (!req_q.we) begin
                  hi_byte_q <= zram_lane_byte(req_q.uds_n, ram_dout);
               end
            end
            TAIL: begin
               dout_q <= {hi_byte_q, zram_lane_byte(req_q.lds_n, ram_dout)};
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zram_bus_bridge.sv
// Bench for zram_bus_bridge: behavioural RAM, transaction-level expectation model and per-cycle compare.
module tb_zram_bus_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
`ifdef ZRAM_BUSGATE_EN
   logic        z80_busack;
`endif

   zram_bus_bridge_if #(.ADDR_WIDTH(16)) cpu_bus ();

   zram_bus_bridge #(.ADDR_WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu        (cpu_bus.slave),
`ifdef ZRAM_BUSGATE_EN
      .z80_busack (z80_busack),
`endif
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout)
   );

   always #5 clk = ~clk;

   // Sound RAM: registered read, write on the clock edge.
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;
   int we_cnt = 0;

   // Expectations keyed by cycle number: RAM writes {addr,data} and ack with its read data.
   logic [23:0] exp_w   [int];
   logic [15:0] exp_ack [int];
   logic [7:0]  model_mem [int];
   logic [15:0] model_dout;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
      end
   endtask

   bit ea, ew;
   always @(negedge clk) begin
      if (cyc > 0) begin
         ea = exp_ack.exists(cyc);
         ew = exp_w.exists(cyc);
         check("cpu_ack", {31'd0, cpu_bus.ack}, {31'd0, ea});
         if (ea && cpu_bus.ack) check("cpu_dout", {16'd0, cpu_bus.dout}, {16'd0, exp_ack[cyc]});
         check("ram_we", {31'd0, ram_we}, {31'd0, ew});
         if (ew && ram_we) check("ram_write", {8'd0, ram_addr, ram_din}, {8'd0, exp_w[cyc]});
         if (cpu_bus.ack) ack_cnt++;
         if (ram_we) we_cnt++;
      end
   end

   // Transaction model: request accepted at the edge after cycle c.
   task automatic model_issue(input bit we, input logic [14:0] a, input bit u_n, input bit l_n,
                              input logic [15:0] d, input int c);
      logic [15:0] ev;
      logic [15:0] od;
      int lat;
      ev = {a, 1'b0};
      od = {a, 1'b1};
      if (u_n && l_n) begin
         lat = 1;
         if (!we) model_dout = 16'hFFFF;
      end else if (we) begin
         lat = 3;
         if (!u_n) begin exp_w[c+1] = {ev, d[15:8]}; model_mem[ev] = d[15:8]; end
         if (!l_n) begin exp_w[c+2] = {od, d[7:0]};  model_mem[od] = d[7:0];  end
      end else begin
         lat = 4;
         model_dout = {u_n ? 8'hFF : model_mem[ev], l_n ? 8'hFF : model_mem[od]};
      end
      exp_ack[c+lat] = model_dout;
   endtask

   task automatic access(input bit we, input logic [14:0] a, input bit u_n, input bit l_n,
                         input logic [15:0] d, input int hold, input int gate,
                         output int lat, output logic [15:0] dout);
      int c;
      @(negedge clk);
      cpu_bus.we    = we;
      cpu_bus.addr  = a;
      cpu_bus.uds_n = u_n;
      cpu_bus.lds_n = l_n;
      cpu_bus.din   = d;
      cpu_bus.req   = 1'b1;
      if (gate > 0) begin
`ifdef ZRAM_BUSGATE_EN
         z80_busack = 1'b0;
         repeat (gate) @(negedge clk);
`endif
      end
`ifdef ZRAM_BUSGATE_EN
      z80_busack = 1'b1;
`endif
      c = cyc;
      model_issue(we, a, u_n, l_n, d, c);
      lat  = -1;
      dout = '0;
      for (int i = 1; i <= 12 && lat < 0; i++) begin
         @(negedge clk);
         cpu_bus.addr = 15'($urandom);
         cpu_bus.din  = 16'($urandom);
`ifdef ZRAM_BUSGATE_EN
         z80_busack = 1'($urandom);
`endif
         if (cpu_bus.ack) begin
            lat  = cyc - c;
            dout = cpu_bus.dout;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout at cycle %0d: got no ack expected ack within 12 cycles", cyc);
      end
      repeat (hold) @(negedge clk);
      cpu_bus.req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

   logic [14:0] pool [8];
   int          lat;
   int          c0;
   int          a0;
   int          w0;
   logic [15:0] dv;
   bit          rwe;
   int          lanes;

   initial begin
      pool = '{15'h0000, 15'h0001, 15'h0008, 15'h1234, 15'h2AAA, 15'h4000, 15'h7FFE, 15'h7FFF};
      rst_n         = 1'b0;
      cpu_bus.req   = 1'b1;
      cpu_bus.we    = 1'b1;
      cpu_bus.addr  = 15'h0001;
      cpu_bus.uds_n = 1'b0;
      cpu_bus.lds_n = 1'b0;
      cpu_bus.din   = 16'hFFFF;
      model_dout    = 16'h0000;
`ifdef ZRAM_BUSGATE_EN
      z80_busack    = 1'b1;
`endif
      repeat (2) begin
         @(negedge clk);
         check("reset_dout", {16'd0, cpu_bus.dout}, 32'h0);
      end
      rst_n       = 1'b1;
      cpu_bus.req = 1'b0;
      @(negedge clk);

      access(1'b1, 15'h1234, 1'b0, 1'b0, 16'hABCD, 0, 0, lat, dv);
      check("write_latency", lat, 3);
      check("write_even", {24'd0, mem[16'h2468]}, 32'hAB);
      check("write_odd", {24'd0, mem[16'h2469]}, 32'hCD);

      access(1'b1, 15'h0008, 1'b0, 1'b0, 16'h5AA5, 0, 0, lat, dv);
      access(1'b0, 15'h0008, 1'b0, 1'b0, 16'h0000, 0, 0, lat, dv);
      check("read_latency", lat, 4);
      check("read_data", {16'd0, dv}, 32'h5AA5);

      access(1'b1, 15'h0008, 1'b1, 1'b0, 16'h11EE, 0, 0, lat, dv);
      check("lds_write_even_kept", {24'd0, mem[16'h0010]}, 32'h5A);
      check("lds_write_odd", {24'd0, mem[16'h0011]}, 32'hEE);

      access(1'b0, 15'h0008, 1'b0, 1'b1, 16'h0000, 0, 0, lat, dv);
      check("uds_read_data", {16'd0, dv}, 32'h5AFF);

      a0 = ack_cnt;
      w0 = we_cnt;
      access(1'b1, 15'h2000, 1'b0, 1'b0, 16'h1357, 10, 0, lat, dv);
      check("hold_ack_count", ack_cnt - a0, 1);
      check("hold_write_count", we_cnt - w0, 2);

      access(1'b0, 15'h0123, 1'b1, 1'b1, 16'h0000, 0, 0, lat, dv);
      check("nolane_latency", lat, 1);
      check("nolane_read", {16'd0, dv}, 32'hFFFF);
      access(1'b1, 15'h0123, 1'b1, 1'b1, 16'h4242, 0, 0, lat, dv);
      check("nolane_write_dout_held", {16'd0, dv}, 32'hFFFF);

      access(1'b1, 15'h7FFF, 1'b0, 1'b0, 16'h9876, 0, 0, lat, dv);
      check("wrap_even", {24'd0, mem[16'hFFFE]}, 32'h98);
      check("wrap_odd", {24'd0, mem[16'hFFFF]}, 32'h76);

      // Reset lands while the even byte is being written: that byte sticks, the odd one never goes out.
      access(1'b1, 15'h0100, 1'b0, 1'b0, 16'h1122, 0, 0, lat, dv);
      @(negedge clk);
      cpu_bus.we    = 1'b1;
      cpu_bus.addr  = 15'h0100;
      cpu_bus.uds_n = 1'b0;
      cpu_bus.lds_n = 1'b0;
      cpu_bus.din   = 16'hC33C;
      cpu_bus.req   = 1'b1;
`ifdef ZRAM_BUSGATE_EN
      z80_busack    = 1'b1;
`endif
      c0 = cyc;
      exp_w[c0+1] = {16'h0200, 8'hC3};
      model_mem[16'h0200] = 8'hC3;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n       = 1'b1;
      cpu_bus.req = 1'b0;
      model_dout  = 16'h0000;
      check("mid_reset_dout", {16'd0, cpu_bus.dout}, 32'h0);
      repeat (2) @(negedge clk);
      check("mid_reset_even", {24'd0, mem[16'h0200]}, 32'hC3);
      check("mid_reset_odd", {24'd0, mem[16'h0201]}, 32'h22);

`ifdef ZRAM_BUSGATE_EN
      access(1'b1, 15'h0040, 1'b0, 1'b0, 16'h2468, 0, 5, lat, dv);
      check("gated_write_latency", lat, 3);
      check("gated_write_even", {24'd0, mem[16'h0080]}, 32'h24);
`endif

      foreach (pool[i]) access(1'b1, pool[i], 1'b0, 1'b0, 16'($urandom), 0, 0, lat, dv);

      for (int n = 0; n < 200; n++) begin
         rwe   = 1'($urandom);
         lanes = $urandom_range(0, 3);
         access(rwe, pool[$urandom_range(0, 7)], lanes[0], lanes[1], 16'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), lat, dv);
      end

      foreach (pool[i]) begin
         check("final_even", {24'd0, mem[{pool[i], 1'b0}]}, {24'd0, model_mem[{pool[i], 1'b0}]});
         check("final_odd", {24'd0, mem[{pool[i], 1'b1}]}, {24'd0, model_mem[{pool[i], 1'b1}]});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
